internal_bus_arbiter: RTL and testbench

- Parametrised successor to the wired-OR internal bus. Replaces the OR-combining of manager address, data and message outputs with a registered round-robin arbiter across N_REQ requesters (memory, thread, channel managers and others).
- Grants exactly one requester at a time and drives a single read_q/write_q/msg_pulse transaction onto the bus.
- Returns read data and completion or timeout status to the granted requester.
- Sits between the per-manager request ports and the external bus/dispatcher.

---
 rtl/internal_bus_arbiter_if.sv | 54 +++++
 rtl/internal_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_internal_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/internal_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : internal_bus_arbiter_if
// Description : Bundle of the requester-side and bus-side signals of the
//               internal bus arbiter.
//                 master : arbiter view (drives grant/done/err, read data and
//                          the bus request strobes, address and data)
//                 slave  : environment view (requesters plus external bus)
//               Ports carried:
//                 bus_busy, m_req, m_we, m_msg, m_addr, m_data  -> arbiter
//                 read_dn, write_dn, data_in                     -> arbiter
//                 m_grant, m_done, m_err, rd_data                <- arbiter
//                 read_q, write_q, msg_pulse, addr_out, data_out <- arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface internal_bus_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                      bus_busy;
    logic [N_REQ-1:0]          m_req;
    logic [N_REQ-1:0]          m_we;
    logic [N_REQ-1:0]          m_msg;
    logic [N_REQ*ADDR_W-1:0]   m_addr;
    logic [N_REQ*DATA_W-1:0]   m_data;
    logic [N_REQ-1:0]          m_grant;
    logic [N_REQ-1:0]          m_done;
    logic [N_REQ-1:0]          m_err;
    logic [DATA_W-1:0]         rd_data;
    logic                      read_q;
    logic                      write_q;
    logic                      msg_pulse;
    logic [ADDR_W-1:0]         addr_out;
    logic [DATA_W-1:0]         data_out;
    logic                      read_dn;
    logic                      write_dn;
    logic [DATA_W-1:0]         data_in;

    modport master (
        input  bus_busy, m_req, m_we, m_msg, m_addr, m_data,
        input  read_dn, write_dn, data_in,
        output m_grant, m_done, m_err, rd_data,
        output read_q, write_q, msg_pulse, addr_out, data_out
    );

    modport slave (
        output bus_busy, m_req, m_we, m_msg, m_addr, m_data,
        output read_dn, write_dn, data_in,
        input  m_grant, m_done, m_err, rd_data,
        input  read_q, write_q, msg_pulse, addr_out, data_out
    );
endinterface
`default_nettype wire

// File: rtl/internal_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : internal_bus_arbiter
// Description : Registered round-robin arbiter for N_REQ bus requesters.
//               Grants one requester at a time, latches its address/data and
//               drives exactly one read_q / write_q / msg_pulse transaction,
//               then returns completion (m_done) or timeout (m_err) and the
//               captured read data to the owner.
//               Ports:
//                 clk  - system clock, rising edge
//                 rst  - asynchronous active-high reset
//                 bus  - internal_bus_arbiter_if.master (requester and
//                        external bus signals)
// Revision    : 1.0 - initial release
// ============================================================================
module internal_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  wire                          clk,
    input  wire                          rst,
    internal_bus_arbiter_if.master       bus
);

    localparam int                 c_idx_w  = $clog2(N_REQ);
    localparam logic [N_REQ-1:0]   c_one    = N_REQ'(1);
    localparam logic [TO_W:0]      c_to_lim = (TO_W + 1)'(TIMEOUT);
    localparam logic [c_idx_w:0]   c_n_req  = (c_idx_w + 1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_MSG  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_last;
    logic [c_idx_w-1:0]   r_owner;
    logic [TO_W-1:0]      r_cnt;

    logic                 w_found;
    logic [c_idx_w-1:0]   w_sel;
    logic [c_idx_w:0]     w_cand;
    logic                 w_match;
    logic                 w_expire;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;

    // Round-robin search: candidates last+1, last+2, ... wrapping at N_REQ.
    // One extra bit on the candidate lets the wrap be a compare-and-subtract.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = {1'b0, r_last} + (c_idx_w + 1)'(k);
            if (w_cand >= c_n_req) begin
                w_cand = w_cand - c_n_req;
            end
            if (!w_found && bus.m_req[w_cand[c_idx_w-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[c_idx_w-1:0];
            end
        end
    end

    assign w_addr = bus.m_addr[w_sel*ADDR_W +: ADDR_W];
    assign w_data = bus.m_data[w_sel*DATA_W +: DATA_W];

    // Only the done strobe matching the transfer direction ends it.
    assign w_match  = (bus.read_q & bus.read_dn) | (bus.write_q & bus.write_dn);
    // Expiry is evaluated on the count this cycle would reach.
    assign w_expire = (TIMEOUT != 0) && (({1'b0, r_cnt} + 1'b1) == c_to_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last        <= c_idx_w'(N_REQ - 1);
            r_owner       <= '0;
            r_cnt         <= '0;
            bus.m_grant   <= '0;
            bus.m_done    <= '0;
            bus.m_err     <= '0;
            bus.rd_data   <= '0;
            bus.read_q    <= 1'b0;
            bus.write_q   <= 1'b0;
            bus.msg_pulse <= 1'b0;
            bus.addr_out  <= '0;
            bus.data_out  <= '0;
        end else begin
            bus.m_done <= '0;
            bus.m_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.bus_busy && w_found) begin
                        r_owner      <= w_sel;
                        r_last       <= w_sel;
                        r_cnt        <= '0;
                        bus.m_grant  <= c_one << w_sel;
                        bus.addr_out <= w_addr;
                        bus.data_out <= w_data;
                        // A message request takes precedence over m_we.
                        if (bus.m_msg[w_sel]) begin
                            bus.msg_pulse <= 1'b1;
                            r_state       <= S_MSG;
                        end else begin
                            bus.read_q  <= ~bus.m_we[w_sel];
                            bus.write_q <= bus.m_we[w_sel];
                            r_state     <= S_XFER;
                        end
                    end
                end

                S_XFER: begin
                    if (w_match || w_expire) begin
                        // Done has priority over a simultaneous expiry.
                        if (w_match) begin
                            bus.m_done <= c_one << r_owner;
                            if (bus.read_q) begin
                                bus.rd_data <= bus.data_in;
                            end
                        end else begin
                            bus.m_err <= c_one << r_owner;
                        end
                        bus.m_grant  <= '0;
                        bus.read_q   <= 1'b0;
                        bus.write_q  <= 1'b0;
                        bus.addr_out <= '0;
                        bus.data_out <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_MSG: begin
                    bus.m_done    <= c_one << r_owner;
                    bus.m_grant   <= '0;
                    bus.msg_pulse <= 1'b0;
                    bus.addr_out  <= '0;
                    bus.data_out  <= '0;
                    r_state       <= S_IDLE;
                end

                default: begin
                    bus.m_grant   <= '0;
                    bus.read_q    <= 1'b0;
                    bus.write_q   <= 1'b0;
                    bus.msg_pulse <= 1'b0;
                    bus.addr_out  <= '0;
                    bus.data_out  <= '0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_internal_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_internal_bus_arbiter
// Description : Self-checking bench for internal_bus_arbiter (N_REQ=4,
//               TIMEOUT=4): directed vector table, round-robin and async
//               reset sequences, then randomized traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_internal_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    internal_bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    internal_bus_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  req, we, msg;
        logic        busy, rdn, wdn;
        logic [31:0] din;
        logic [3:0]  grant, done, err;
        logic        rq, wq, mp;
        logic [31:0] addr, data, rd;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(
        input logic [3:0] req, input logic [3:0] we, input logic [3:0] msg,
        input logic busy, input logic rdn, input logic wdn, input logic [31:0] din,
        input logic [3:0] grant, input logic [3:0] done, input logic [3:0] err,
        input logic rq, input logic wq, input logic mp,
        input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rd);
        vec_t v;
        v.req = req; v.we = we; v.msg = msg; v.busy = busy; v.rdn = rdn; v.wdn = wdn;
        v.din = din; v.grant = grant; v.done = done; v.err = err;
        v.rq = rq; v.wq = wq; v.mp = mp; v.addr = addr; v.data = data; v.rd = rd;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks the owning transaction as (owner, kind, age)
    // ------------------------------------------------------------------
    int          mo_owner;
    int          mo_kind;   // 0 read, 1 write, 2 message
    int          mo_age;
    int          mo_last;
    logic [3:0]  e_grant, e_done, e_err;
    logic        e_rq, e_wq, e_mp;
    logic [31:0] e_addr, e_data, e_rd;

    task automatic model_reset();
        mo_owner = -1; mo_kind = 0; mo_age = 0; mo_last = N - 1;
        e_grant = '0; e_done = '0; e_err = '0;
        e_rq = 1'b0; e_wq = 1'b0; e_mp = 1'b0;
        e_addr = '0; e_data = '0; e_rd = '0;
    endtask

    task automatic model_step();
        bit fin;
        fin    = 1'b0;
        e_done = '0;
        e_err  = '0;
        if (mo_owner < 0) begin
            if (!bus_if.bus_busy && bus_if.m_req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (mo_last + k) % N;
                    if (mo_owner < 0 && bus_if.m_req[c]) mo_owner = c;
                end
                mo_last = mo_owner;
                mo_age  = 0;
                mo_kind = bus_if.m_msg[mo_owner] ? 2 : (bus_if.m_we[mo_owner] ? 1 : 0);
                e_grant = 4'(1 << mo_owner);
                e_addr  = bus_if.m_addr[mo_owner*AW +: AW];
                e_data  = bus_if.m_data[mo_owner*DW +: DW];
                e_rq    = (mo_kind == 0);
                e_wq    = (mo_kind == 1);
                e_mp    = (mo_kind == 2);
            end
        end else begin
            if (mo_kind == 2) begin
                e_done = 4'(1 << mo_owner);
                fin    = 1'b1;
            end else begin
                mo_age++;
                if ((mo_kind == 0 && bus_if.read_dn) || (mo_kind == 1 && bus_if.write_dn)) begin
                    if (mo_kind == 0) e_rd = bus_if.data_in;
                    e_done = 4'(1 << mo_owner);
                    fin    = 1'b1;
                end else if (TO != 0 && mo_age == TO) begin
                    e_err = 4'(1 << mo_owner);
                    fin   = 1'b1;
                end
            end
            if (fin) begin
                mo_owner = -1;
                e_grant = '0; e_rq = 1'b0; e_wq = 1'b0; e_mp = 1'b0;
                e_addr = '0; e_data = '0;
            end
        end
    endtask

    task automatic zero_inputs();
        bus_if.bus_busy = 1'b0;
        bus_if.m_req    = '0;
        bus_if.m_we     = '0;
        bus_if.m_msg    = '0;
        bus_if.read_dn  = 1'b0;
        bus_if.write_dn = 1'b0;
        bus_if.data_in  = '0;
        for (int i = 0; i < N; i++) begin
            bus_if.m_addr[i*AW +: AW] = 32'(256 + 16 * i);
            bus_if.m_data[i*DW +: DW] = 32'(83 + i);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " grant"},     32'(bus_if.m_grant),   32'h0);
        chk({tag, " done"},      32'(bus_if.m_done),    32'h0);
        chk({tag, " err"},       32'(bus_if.m_err),     32'h0);
        chk({tag, " read_q"},    32'(bus_if.read_q),    32'h0);
        chk({tag, " write_q"},   32'(bus_if.write_q),   32'h0);
        chk({tag, " msg_pulse"}, 32'(bus_if.msg_pulse), 32'h0);
        chk({tag, " addr_out"},  bus_if.addr_out,       32'h0);
        chk({tag, " data_out"},  bus_if.data_out,       32'h0);
    endtask

    initial begin
        // Slot i: address 0x100 + 0x10*i, data 0x53 + i
        tbl[0]  = mk(4'h1,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'h0);
        tbl[1]  = mk(4'h1,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'h0);
        tbl[2]  = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'h0);
        tbl[3]  = mk(4'h0,4'h0,4'h0,1'b0,1'b1,1'b0,32'hDEADBEEF, 4'h0,4'h1,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF);
        tbl[4]  = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF);
        tbl[5]  = mk(4'h4,4'h0,4'h4,1'b0,1'b0,1'b0,32'h0,        4'h4,4'h0,4'h0,1'b0,1'b0,1'b1,32'h120,32'h55,32'hDEADBEEF);
        tbl[6]  = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h4,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF);
        tbl[7]  = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF);
        tbl[8]  = mk(4'h1,4'h1,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b0,1'b1,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[9]  = mk(4'h0,4'h0,4'h0,1'b0,1'b1,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b0,1'b1,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[10] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b0,1'b1,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[11] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b0,1'b1,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[12] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h1,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF);
        tbl[13] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF);
        tbl[14] = mk(4'h1,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[15] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b1,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[16] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[17] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h1,4'h0,4'h0,1'b1,1'b0,1'b0,32'h100,32'h53,32'hDEADBEEF);
        tbl[18] = mk(4'h0,4'h0,4'h0,1'b0,1'b1,1'b0,32'h12345678, 4'h0,4'h1,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h12345678);
        tbl[19] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h12345678);
        tbl[20] = mk(4'h3,4'h0,4'h0,1'b1,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h12345678);
        tbl[21] = mk(4'h3,4'h0,4'h0,1'b1,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h12345678);
        tbl[22] = mk(4'h3,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h2,4'h0,4'h0,1'b1,1'b0,1'b0,32'h110,32'h54,32'h12345678);
        tbl[23] = mk(4'h0,4'h0,4'h0,1'b0,1'b1,1'b0,32'hA5A5A5A5, 4'h0,4'h2,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hA5A5A5A5);
        tbl[24] = mk(4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,        4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'hA5A5A5A5);

        // ---------------- reset state ----------------
        rst = 1'b1;
        zero_inputs();
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        chk("reset rd_data", bus_if.rd_data, 32'h0);

        // ---------------- round robin: writes, done one cycle after write_q
        bus_if.m_req = 4'hF;
        bus_if.m_we  = 4'hF;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("rr%0d grant", g),   32'(bus_if.m_grant), 32'(1 << (g % N)));
            chk($sformatf("rr%0d write_q", g), 32'(bus_if.write_q), 32'h1);
            chk($sformatf("rr%0d addr", g),    bus_if.addr_out,     32'(256 + 16 * (g % N)));
            bus_if.write_dn = 1'b1;
            tick();
            bus_if.write_dn = 1'b0;
            chk($sformatf("rr%0d done", g),      32'(bus_if.m_done),  32'(1 << (g % N)));
            chk($sformatf("rr%0d idle addr", g), bus_if.addr_out,     32'h0);
            chk($sformatf("rr%0d idle grant", g), 32'(bus_if.m_grant), 32'h0);
        end
        zero_inputs();
        tick();

        // ---------------- directed vector table ----------------
        for (int r = 0; r < 25; r++) begin
            bus_if.m_req    = tbl[r].req;
            bus_if.m_we     = tbl[r].we;
            bus_if.m_msg    = tbl[r].msg;
            bus_if.bus_busy = tbl[r].busy;
            bus_if.read_dn  = tbl[r].rdn;
            bus_if.write_dn = tbl[r].wdn;
            bus_if.data_in  = tbl[r].din;
            tick();
            chk($sformatf("vec%0d grant", r),     32'(bus_if.m_grant),   32'(tbl[r].grant));
            chk($sformatf("vec%0d done", r),      32'(bus_if.m_done),    32'(tbl[r].done));
            chk($sformatf("vec%0d err", r),       32'(bus_if.m_err),     32'(tbl[r].err));
            chk($sformatf("vec%0d read_q", r),    32'(bus_if.read_q),    32'(tbl[r].rq));
            chk($sformatf("vec%0d write_q", r),   32'(bus_if.write_q),   32'(tbl[r].wq));
            chk($sformatf("vec%0d msg_pulse", r), 32'(bus_if.msg_pulse), 32'(tbl[r].mp));
            chk($sformatf("vec%0d addr_out", r),  bus_if.addr_out,       tbl[r].addr);
            chk($sformatf("vec%0d data_out", r),  bus_if.data_out,       tbl[r].data);
            chk($sformatf("vec%0d rd_data", r),   bus_if.rd_data,        tbl[r].rd);
        end

        // ---------------- asynchronous reset mid-transfer ----------------
        zero_inputs();
        bus_if.m_req = 4'h2;
        tick();
        chk("pre_rst read_q", 32'(bus_if.read_q), 32'h1);
        bus_if.m_req = 4'h0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        chk("async_rst rd_data", bus_if.rd_data, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst done", 32'(bus_if.m_done), 32'h0);
        chk("post_rst err",  32'(bus_if.m_err),  32'h0);
        bus_if.m_req = 4'h3;
        tick();
        chk("post_rst first grant", 32'(bus_if.m_grant), 32'h1);
        bus_if.m_req   = 4'h0;
        bus_if.read_dn = 1'b1;
        tick();
        bus_if.read_dn = 1'b0;

        // ---------------- randomized traffic vs. reference model ----------------
        rst = 1'b1;
        zero_inputs();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus_if.m_req    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            bus_if.m_we     = 4'($urandom);
            bus_if.m_msg    = 4'($urandom & $urandom);
            bus_if.bus_busy = ($urandom_range(0, 7) == 0);
            bus_if.read_dn  = ($urandom_range(0, 3) == 0);
            bus_if.write_dn = ($urandom_range(0, 3) == 0);
            bus_if.data_in  = $urandom;
            for (int i = 0; i < N; i++) begin
                bus_if.m_addr[i*AW +: AW] = $urandom;
                bus_if.m_data[i*DW +: DW] = $urandom;
            end
            tick();
            model_step();
            chk($sformatf("rnd%0d grant", cyc),     32'(bus_if.m_grant),   32'(e_grant));
            chk($sformatf("rnd%0d done", cyc),      32'(bus_if.m_done),    32'(e_done));
            chk($sformatf("rnd%0d err", cyc),       32'(bus_if.m_err),     32'(e_err));
            chk($sformatf("rnd%0d read_q", cyc),    32'(bus_if.read_q),    32'(e_rq));
            chk($sformatf("rnd%0d write_q", cyc),   32'(bus_if.write_q),   32'(e_wq));
            chk($sformatf("rnd%0d msg_pulse", cyc), 32'(bus_if.msg_pulse), 32'(e_mp));
            chk($sformatf("rnd%0d addr_out", cyc),  bus_if.addr_out,       e_addr);
            chk($sformatf("rnd%0d data_out", cyc),  bus_if.data_out,       e_data);
            chk($sformatf("rnd%0d rd_data", cyc),   bus_if.rd_data,        e_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
